// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer and its program store.
// Holds the default program image that the constant ROM build is initialised from.
package cpu_pkg;

  localparam int PC_W       = 4;
  localparam int OPCODE_W   = 8;
  localparam int PROG_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } seq_state_t;

  localparam logic [OPCODE_W-1:0] NOP = 8'h00;

  // Leftmost entry is address 15; address 3 jumps to address 10.
  localparam logic [PROG_DEPTH-1:0][OPCODE_W-1:0] DEFAULT_PROG = '{
    8'h3F, 8'h2E, 8'h0D, 8'hFC, 8'hEB, 8'hDA, 8'hC9, 8'hB8,
    8'hA7, 8'h96, 8'h85, 8'h74, 8'h1A, 8'h63, 8'h52, 8'h41
  };

  function automatic logic [PC_W-1:0] next_pc(
    input logic [PC_W-1:0] pc,
    input logic            write_pc,
    input logic            pc_sel,
    input logic [PC_W-1:0] jump_target
  );
    logic [PC_W-1:0] result;
    result = pc;
    if (write_pc) begin
      result = pc_sel ? jump_target : pc + PC_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/program_rom.sv
// 16x8 program store: combinational read; write port only with SEQ_PROG_LOAD_EN.
// Latency: read 0 cycles, write visible after the writing edge; no backpressure.
module program_rom
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]     raddr,
  output logic [OPCODE_W-1:0] rdata
`ifdef SEQ_PROG_LOAD_EN
  ,
  input  logic                clk,
  input  logic                we,
  input  logic [PC_W-1:0]     waddr,
  input  logic [OPCODE_W-1:0] wdata
`endif
);

`ifdef SEQ_PROG_LOAD_EN
  // No reset: contents must survive a sequencer reset.
  logic [OPCODE_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
`else
  assign rdata = DEFAULT_PROG[raddr];
`endif

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: IDLE -> FETCH -> EXEC, 2 cycles per instruction; SEQ_PROG_LOAD_EN adds program load.
// No backpressure: run_i only gates entry to the next FETCH, an started instruction always completes.
module instruction_sequencer
  import cpu_pkg::*;
(
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                run_i,
  input  logic                write_pc_i,
  input  logic                pc_sel_i,
`ifdef SEQ_PROG_LOAD_EN
  input  logic                prog_we_i,
  input  logic [PC_W-1:0]     prog_addr_i,
  input  logic [OPCODE_W-1:0] prog_data_i,
`endif
  output logic [OPCODE_W-1:0] opcode_o,
  output logic                valid_o,
  output logic [PC_W-1:0]     pc_o,
  output logic [1:0]          state_o
);

  seq_state_t          state;
  logic [OPCODE_W-1:0] rom_dat;

`ifdef SEQ_PROG_LOAD_EN
  // Loading is only allowed while the sequencer is parked.
  logic mem_we;
  assign mem_we = prog_we_i && (state == IDLE);

  program_rom u_program_rom (
    .raddr (pc_o),
    .rdata (rom_dat),
    .clk   (in_clk),
    .we    (mem_we),
    .waddr (prog_addr_i),
    .wdata (prog_data_i)
  );
`else
  program_rom u_program_rom (
    .raddr (pc_o),
    .rdata (rom_dat)
  );
`endif

  assign state_o = state;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state    <= IDLE;
      pc_o     <= '0;
      opcode_o <= NOP;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (run_i) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          opcode_o <= rom_dat;
          valid_o  <= 1'b1;
          state    <= EXEC;
        end
        EXEC: begin
          // PC update happens whether or not we continue running.
          valid_o <= 1'b0;
          pc_o    <= next_pc(pc_o, write_pc_i, pc_sel_i, opcode_o[PC_W-1:0]);
          state   <= run_i ? FETCH : IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed plus randomized bench for instruction_sequencer against a behavioural model.
// Works in the default build and with SEQ_PROG_LOAD_EN defined.
module tb_instruction_sequencer;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       run_i, write_pc_i, pc_sel_i;
  logic [7:0] opcode_o;
  logic       valid_o;
  logic [3:0] pc_o;
  logic [1:0] state_o;
`ifdef SEQ_PROG_LOAD_EN
  logic       prog_we_i;
  logic [3:0] prog_addr_i;
  logic [7:0] prog_data_i;
`endif

  always #5 in_clk = ~in_clk;

  instruction_sequencer dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .run_i       (run_i),
    .write_pc_i  (write_pc_i),
    .pc_sel_i    (pc_sel_i),
`ifdef SEQ_PROG_LOAD_EN
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
`endif
    .opcode_o    (opcode_o),
    .valid_o     (valid_o),
    .pc_o        (pc_o),
    .state_o     (state_o)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle 1=fetch 2=exec, plain integer PC arithmetic.
  int m_phase, m_pc, m_op;
`ifdef SEQ_PROG_LOAD_EN
  logic [7:0] m_mem [16];
`endif

  function automatic int m_read(input int addr);
`ifdef SEQ_PROG_LOAD_EN
    return int'(m_mem[addr]);
`else
    return int'(cpu_pkg::DEFAULT_PROG[addr]);
`endif
  endfunction

  always @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_phase <= 0;
      m_pc    <= 0;
      m_op    <= 0;
    end else begin
`ifdef SEQ_PROG_LOAD_EN
      if (m_phase == 0 && prog_we_i) m_mem[prog_addr_i] <= prog_data_i;
`endif
      if (m_phase == 0) begin
        if (run_i) m_phase <= 1;
      end else if (m_phase == 1) begin
        m_op    <= m_read(m_pc);
        m_phase <= 2;
      end else begin
        if (write_pc_i) m_pc <= pc_sel_i ? (m_op % 16) : ((m_pc + 1) % 16);
        m_phase <= run_i ? 1 : 0;
      end
    end
  end

  always @(negedge in_clk) begin
    if (cmp_en) begin
      chk("state", {30'd0, state_o}, m_phase);
      chk("valid", {31'd0, valid_o}, {31'd0, m_phase == 2});
      chk("pc", {28'd0, pc_o}, m_pc);
      chk("opcode", {24'd0, opcode_o}, m_op);
    end
  end

  task automatic set_prog(input logic we, input logic [3:0] addr, input logic [7:0] data);
`ifdef SEQ_PROG_LOAD_EN
    prog_we_i   = we;
    prog_addr_i = addr;
    prog_data_i = data;
`else
    if (we && (addr != data[3:0])) begin end
`endif
  endtask

  task automatic tick(input logic r, input logic w, input logic s);
    run_i      = r;
    write_pc_i = w;
    pc_sel_i   = s;
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  initial begin
    in_rst_n = 1'b1;
    run_i = 1'b0; write_pc_i = 1'b0; pc_sel_i = 1'b0;
    set_prog(1'b0, 4'h0, 8'h00);
    #1 in_rst_n = 1'b0;
    #2;
    chk("reset_state", {30'd0, state_o}, 32'h0);
    chk("reset_pc", {28'd0, pc_o}, 32'h0);
    chk("reset_opcode", {24'd0, opcode_o}, 32'h0);
    chk("reset_valid", {31'd0, valid_o}, 32'h0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    cmp_en   = 1'b1;

`ifdef SEQ_PROG_LOAD_EN
    for (int i = 0; i < 16; i++) begin
      set_prog(1'b1, 4'(i), cpu_pkg::DEFAULT_PROG[i]);
      tick(1'b0, 1'b0, 1'b0);
    end
    set_prog(1'b0, 4'h0, 8'h00);
`endif

    // First instruction: 0x41 presented with valid on the second cycle.
    tick(1'b1, 1'b1, 1'b0);
    chk("first_fetch_state", {30'd0, state_o}, 32'h1);
    chk("first_fetch_valid", {31'd0, valid_o}, 32'h0);
    tick(1'b1, 1'b1, 1'b0);
    chk("first_op", {24'd0, opcode_o}, 32'h41);
    chk("first_valid", {31'd0, valid_o}, 32'h1);
    tick(1'b1, 1'b1, 1'b0);
    chk("first_pc", {28'd0, pc_o}, 32'h1);
    repeat (4) tick(1'b1, 1'b1, 1'b0);

    // Jump from address 3 via opcode 0x1A.
    tick(1'b1, 1'b1, 1'b1);
    chk("jump_op", {24'd0, opcode_o}, 32'h1A);
    tick(1'b1, 1'b1, 1'b1);
    chk("jump_pc", {28'd0, pc_o}, 32'hA);
    tick(1'b1, 1'b1, 1'b0);
    chk("jump_target_op", {24'd0, opcode_o}, 32'hDA);
    tick(1'b1, 1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b1, 1'b0);
    chk("pc_at_f", {28'd0, pc_o}, 32'hF);

    // Wrap from 0xF to 0x0.
    tick(1'b1, 1'b1, 1'b0);
    chk("last_op", {24'd0, opcode_o}, 32'h3F);
    tick(1'b1, 1'b1, 1'b0);
    chk("wrap_pc", {28'd0, pc_o}, 32'h0);

    // NOP hold: same instruction refetched three times.
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      chk("hold_op", {24'd0, opcode_o}, 32'h41);
      chk("hold_valid", {31'd0, valid_o}, 32'h1);
      tick(1'b1, 1'b0, 1'b0);
      chk("hold_pc", {28'd0, pc_o}, 32'h0);
    end

    // Drop run during FETCH: instruction still executes, then IDLE.
    tick(1'b0, 1'b1, 1'b0);
    chk("drop_exec_valid", {31'd0, valid_o}, 32'h1);
    tick(1'b0, 1'b1, 1'b0);
    chk("drop_idle_state", {30'd0, state_o}, 32'h0);
    chk("drop_idle_valid", {31'd0, valid_o}, 32'h0);
    chk("drop_pc", {28'd0, pc_o}, 32'h1);
    tick(1'b0, 1'b1, 1'b0);
    chk("stay_idle", {30'd0, state_o}, 32'h0);

    // Write and run on the same IDLE edge; FETCH then sees the new word.
    set_prog(1'b1, 4'h1, 8'h99);
    tick(1'b1, 1'b1, 1'b0);
    set_prog(1'b1, 4'h2, 8'hEE);
    tick(1'b1, 1'b1, 1'b0);
`ifdef SEQ_PROG_LOAD_EN
    chk("load_run_op", {24'd0, opcode_o}, 32'h99);
`else
    chk("load_run_op", {24'd0, opcode_o}, 32'h52);
`endif

    // Reset in the middle of EXEC.
    #2;
    set_prog(1'b0, 4'h0, 8'h00);
    in_rst_n = 1'b0;
    #1;
    chk("midexec_rst_valid", {31'd0, valid_o}, 32'h0);
    chk("midexec_rst_pc", {28'd0, pc_o}, 32'h0);
    chk("midexec_rst_op", {24'd0, opcode_o}, 32'h0);
    chk("midexec_rst_state", {30'd0, state_o}, 32'h0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // Memory retained; an EXEC-time write to address 2 is ignored.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("post_rst_op", {24'd0, opcode_o}, 32'h41);
    set_prog(1'b1, 4'h2, 8'hEE);
    tick(1'b1, 1'b1, 1'b0);
    set_prog(1'b0, 4'h0, 8'h00);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("retained_mem2", {24'd0, opcode_o}, 32'h63);

    // Randomized run checked cycle-by-cycle by the model.
    for (int c = 0; c < 400; c++) begin
      set_prog(($urandom % 4) == 0, 4'($urandom), 8'($urandom));
      tick(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
